// File: rtl/tick_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tick_pkg : shared encodings for the multi_tick_timer timebase          |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package tick_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  localparam int DEFAULT_PERIOD = 50000;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } ch_state_t;

endpackage
`default_nettype wire

// File: rtl/tick_channel.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tick_channel : one programmable periodic / one-shot tick channel       |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tick_channel
  import tick_pkg::*;
#(
  parameter int               CNT_W      = 16,
  parameter logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD)
) (
  input  logic             CLK,
  input  logic             Rst,
  input  logic             i_ce,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic             i_clr,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_period,
  output logic             o_tick,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_count
);

  ch_state_t        r_state;
  ch_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_period_nxt;
  logic             r_tick;
  logic             w_tick_nxt;
  logic             w_adv;
  logic             w_terminal;

  // A zero period never advances, so count stays pinned at 0.
  assign w_adv      = i_en & i_ce & (r_state == ST_RUN) & (r_period != '0);
  assign w_terminal = (r_count == (r_period - CNT_W'(1)));

  always_ff @(posedge CLK) begin
    if (Rst) begin
      r_state  <= ST_RUN;
      r_count  <= '0;
      r_period <= RST_PERIOD;
      r_tick   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_period <= w_period_nxt;
      r_tick   <= w_tick_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_period_nxt = r_period;
    w_tick_nxt   = 1'b0;
    if (i_wr) begin
      w_period_nxt = i_wr_period;
      w_count_nxt  = '0;
      w_state_nxt  = ST_RUN;
    end else if (i_clr) begin
      w_count_nxt  = '0;
      w_state_nxt  = ST_RUN;
    end else if (w_adv) begin
      if (w_terminal) begin
        w_count_nxt = '0;
        w_tick_nxt  = 1'b1;
        if (i_mode == MODE_ONESHOT) begin
          w_state_nxt = ST_DONE;
        end
      end else begin
        w_count_nxt = r_count + CNT_W'(1);
      end
    end
  end

  assign o_tick  = r_tick;
  assign o_busy  = (r_state == ST_RUN) & (r_period != '0);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/multi_tick_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | multi_tick_timer : shared prescaler driving NUM_CH tick channels       |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module multi_tick_timer #(
  parameter  int CNT_W          = 16,
  parameter  int NUM_CH         = 4,
  parameter  int PRE_W          = 8,
  parameter  int DEFAULT_PERIOD = tick_pkg::DEFAULT_PERIOD,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    CLK,
  input  logic                    Rst,
  input  logic [PRE_W-1:0]        i_pre_div,
  input  logic [NUM_CH-1:0]       i_en,
  input  logic [NUM_CH-1:0]       i_mode,
  input  logic [NUM_CH-1:0]       i_clr,
  input  logic                    i_cfg_we,
  input  logic [CH_W-1:0]         i_cfg_ch,
  input  logic [CNT_W-1:0]        i_cfg_period,
  output logic [NUM_CH-1:0]       o_tick,
  output logic [NUM_CH-1:0]       o_busy,
  output logic [NUM_CH*CNT_W-1:0] o_count
);

  import tick_pkg::*;

  logic [PRE_W-1:0]  r_pre_cnt;
  logic              w_ce;
  logic [NUM_CH-1:0] w_wr;

  // Equality match only: a smaller pre_div written mid-count wraps the full range.
  assign w_ce = (r_pre_cnt == i_pre_div);

  always_ff @(posedge CLK) begin
    if (Rst) begin
      r_pre_cnt <= '0;
    end else if (w_ce) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + PRE_W'(1);
    end
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // Channel indices >= NUM_CH match no decode term and are dropped.
      assign w_wr[i] = i_cfg_we & (i_cfg_ch == CH_W'(i));

      tick_channel #(
        .CNT_W      (CNT_W),
        .RST_PERIOD (CNT_W'(DEFAULT_PERIOD))
      ) u_ch (
        .CLK         (CLK),
        .Rst         (Rst),
        .i_ce        (w_ce),
        .i_en        (i_en[i]),
        .i_mode      (i_mode[i]),
        .i_clr       (i_clr[i]),
        .i_wr        (w_wr[i]),
        .i_wr_period (i_cfg_period),
        .o_tick      (o_tick[i]),
        .o_busy      (o_busy[i]),
        .o_count     (o_count[i*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_tick_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_multi_tick_timer : directed bench with a tick scoreboard            |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_multi_tick_timer;

  localparam int CNT_W = 16;
  localparam int NCH   = 5;   // non power of two leaves cfg_ch codes 5..7 unused
  localparam int PRE_W = 8;
  localparam int CH_W  = 3;
  localparam int DEF_P = 50000;

  logic                  CLK = 1'b0;
  logic                  Rst;
  logic [PRE_W-1:0]      pre_div;
  logic [NCH-1:0]        en, mode, clr;
  logic                  cfg_we;
  logic [CH_W-1:0]       cfg_ch;
  logic [CNT_W-1:0]      cfg_period;
  wire  [NCH-1:0]        tick, busy;
  wire  [NCH*CNT_W-1:0]  count;

  multi_tick_timer #(
    .CNT_W          (CNT_W),
    .NUM_CH         (NCH),
    .PRE_W          (PRE_W),
    .DEFAULT_PERIOD (DEF_P)
  ) dut (
    .CLK          (CLK),
    .Rst          (Rst),
    .i_pre_div    (pre_div),
    .i_en         (en),
    .i_mode       (mode),
    .i_clr        (clr),
    .i_cfg_we     (cfg_we),
    .i_cfg_ch     (cfg_ch),
    .i_cfg_period (cfg_period),
    .o_tick       (tick),
    .o_busy       (busy),
    .o_count      (count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int ch;
    int at;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint cnt(input int ch);
    return longint'(count[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic push(input int ch, input int at);
    sb.push_back('{ch, at});
  endtask

  // One CLK: sample on the falling edge and retire any ticks against the queue.
  task automatic step();
    exp_t e;
    @(negedge CLK);
    cyc++;
    for (int ch = 0; ch < NCH; ch++) begin
      if (tick[ch] !== 1'b0) begin
        if (sb.size() > 0) e = sb.pop_front();
        else               e = '{-1, -1};
        chk($sformatf("tick_channel_ch%0d", ch), ch, e.ch);
        chk($sformatf("tick_cycle_ch%0d", ch), cyc, e.at);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    int base;
    Rst = 1'b1; pre_div = '0; en = '1; mode = '0; clr = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
    run(3);

    // Reset state
    for (int ch = 0; ch < NCH; ch++) chk($sformatf("rst_count_ch%0d", ch), cnt(ch), 0);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 5'h1f);

    // Default period, ce every CLK
    Rst = 1'b0;
    base = cyc;
    for (int ch = 0; ch < NCH; ch++) push(ch, base + DEF_P);
    run(DEF_P - 1);
    chk("t1_count_terminal", cnt(0), DEF_P - 1);
    run(1);
    chk("t1_count_wrap", cnt(0), 0);
    chk("t1_drained", sb.size(), 0);

    // Prescaled periodic channel
    base = cyc;
    pre_div = 8'd3; cfg_we = 1'b1; cfg_ch = 3'd1; cfg_period = 16'd5;
    push(1, base + 20); push(1, base + 40); push(1, base + 60);
    step();
    cfg_we = 1'b0;
    run(3);
    chk("t2_count_after_ce", cnt(1), 1);
    run(56);
    chk("t2_drained", sb.size(), 0);
    en[1] = 1'b0;

    // One-shot, then clr re-arm
    base = cyc;
    pre_div = 8'd0; mode[2] = 1'b1; cfg_we = 1'b1; cfg_ch = 3'd2; cfg_period = 16'd3;
    push(2, base + 4);
    step();
    cfg_we = 1'b0;
    run(3);
    chk("t3_busy_done", busy[2], 0);
    run(5);
    chk("t3_count_done", cnt(2), 0);
    chk("t3_busy_still_done", busy[2], 0);
    chk("t3_drained", sb.size(), 0);
    base = cyc;
    clr[2] = 1'b1;
    push(2, base + 4);
    step();
    clr[2] = 1'b0;
    chk("t3_rearm_busy", busy[2], 1);
    run(3);
    chk("t3_busy_done2", busy[2], 0);
    chk("t3_drained2", sb.size(), 0);

    // Pause holds count
    base = cyc;
    cfg_we = 1'b1; cfg_ch = 3'd0; cfg_period = 16'd10;
    step();
    cfg_we = 1'b0;
    run(7);
    chk("t4_count_before_pause", cnt(0), 7);
    en[0] = 1'b0;
    run(10);
    chk("t4_count_held", cnt(0), 7);
    en[0] = 1'b1;
    push(0, base + 21);
    run(3);
    chk("t4_drained", sb.size(), 0);
    en[0] = 1'b0;

    // cfg write on the terminal advance suppresses the tick
    base = cyc;
    cfg_we = 1'b1; cfg_ch = 3'd3; cfg_period = 16'd4;
    push(3, base + 5);
    step();
    cfg_we = 1'b0;
    run(7);
    chk("t5_count_terminal", cnt(3), 3);
    cfg_we = 1'b1; cfg_ch = 3'd3; cfg_period = 16'd6;
    step();
    cfg_we = 1'b0;
    chk("t5_count_after_write", cnt(3), 0);
    chk("t5_tick_suppressed", tick[3], 0);
    push(3, base + 15);
    run(6);
    chk("t5_new_period", sb.size(), 0);
    run(2);
    en[3] = 1'b0;
    chk("t5_count_paused", cnt(3), 2);

    // Out-of-range channel writes are ignored
    cfg_we = 1'b1; cfg_ch = 3'd5; cfg_period = 16'd2;
    step();
    cfg_ch = 3'd7;
    step();
    cfg_we = 1'b0;
    step();
    chk("t5_bad_ch_count3", cnt(3), 2);
    chk("t5_bad_ch_busy", busy, 5'b11011);

    // Reset mid-period restores defaults
    en = '1;
    Rst = 1'b1;
    step();
    for (int ch = 0; ch < NCH; ch++) chk($sformatf("t6_rst_count_ch%0d", ch), cnt(ch), 0);
    chk("t6_rst_tick", tick, 0);
    chk("t6_rst_busy", busy, 5'h1f);
    Rst = 1'b0;
    run(20);
    chk("t6_period_ch0_restored", cnt(0), 20);
    chk("t6_period_ch2_restored", cnt(2), 20);

    // Zero period makes a channel inert
    cfg_we = 1'b1; cfg_ch = 3'd1; cfg_period = 16'd0;
    step();
    cfg_we = 1'b0;
    chk("t6_zero_busy", busy[1], 0);
    chk("t6_zero_count", cnt(1), 0);
    run(30);
    chk("t6_zero_count_held", cnt(1), 0);
    chk("t6_zero_busy_held", busy[1], 0);
    chk("final_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
